// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: a small byte FIFO feeds an 8N1 serializer
// whose bit period (BAUD_DIV+1 clocks) is programmable at run time.
module uart_tx_periph #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [15:0] BAUD_DIV_RESET = 16'd433
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        mem_sel,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic        mem_wr,
  input  logic [11:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        uart_tx
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  localparam logic [9:0] REG_DATA   = 10'h000;
  localparam logic [9:0] REG_STATUS = 10'h001;
  localparam logic [9:0] REG_BAUD   = 10'h002;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic             ready_q, ready_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [15:0]      baud_div_q, baud_div_d;
  logic             overflow_q, overflow_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  state_e           state_q, state_d;
  logic [15:0]      timer_q, timer_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic             accept, reg_wr, reg_rd;
  logic [9:0]       reg_idx;
  logic             wr_data, wr_status, wr_baud;
  logic             fifo_full, fifo_empty, push, pop, bit_done;
  logic [31:0]      status;
  logic             unused_bits;

  assign accept      = mem_valid & mem_sel & ~ready_q;
  assign reg_idx     = mem_addr[11:2];
  assign reg_wr      = accept & mem_wr;
  assign reg_rd      = accept & ~mem_wr;
  assign wr_data     = reg_wr & (reg_idx == REG_DATA);
  assign wr_status   = reg_wr & (reg_idx == REG_STATUS);
  assign wr_baud     = reg_wr & (reg_idx == REG_BAUD);

  assign fifo_full   = (level_q == LVL_W'(FIFO_DEPTH));
  assign fifo_empty  = (level_q == '0);
  assign push        = wr_data & ~fifo_full;
  assign pop         = (state_q == IDLE) & ~fifo_empty;
  assign bit_done    = (timer_q == '0);
  assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:16]};

  always_comb begin
    status        = '0;
    status[0]     = fifo_full;
    status[1]     = fifo_empty;
    status[2]     = (state_q != IDLE);
    status[3]     = overflow_q;
    status[15:8]  = 8'(level_q);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    ready_d    = accept;
    rdata_d    = '0;
    baud_div_d = baud_div_q;
    overflow_d = overflow_q;
    if (reg_rd) begin
      case (reg_idx)
        REG_STATUS: rdata_d = status;
        REG_BAUD:   rdata_d = {16'h0000, baud_div_q};
        default:    rdata_d = '0;
      endcase
    end
    if (wr_baud) baud_div_d = mem_wdata[15:0];
    if (wr_status && mem_wdata[3]) overflow_d = 1'b0;
    // A dropped byte sets overflow even if a clear lands in the same cycle.
    if (wr_data && fifo_full) overflow_d = 1'b1;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = bit_done ? timer_q : timer_q - 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    tx_d      = 1'b1;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = START;
          shift_d = fifo_mem[rd_ptr_q];
          timer_d = baud_div_q;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          timer_d   = baud_div_q;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          timer_d   = baud_div_q;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      baud_div_q <= BAUD_DIV_RESET;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      ready_q    <= ready_d;
      rdata_q    <= rdata_d;
      baud_div_q <= baud_div_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and level alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_wdata[7:0];
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign uart_tx   = tx_q;

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of transmit FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have parameter BAUD_DIV_RESET, default 16'd433, meaning the reset value of BAUD_DIV; bit period is BAUD_DIV+1 clocks.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_  input  1  synchronous, active-low reset.
REQ-005 SHALL have port mem_sel  input  1  address decoder select for this peripheral.
REQ-006 SHALL have port mem_valid  input  1  CPU bus request valid.
REQ-007 SHALL have port mem_ready  output  1  one-cycle access completion.
REQ-008 SHALL have port mem_wr  input  1  request is a write (OR of byte strobes).
REQ-009 SHALL have port mem_addr  input  12  byte offset within the peripheral window.
REQ-010 SHALL have port mem_wdata  input  32  write data.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid while mem_ready=1, otherwise 0.
REQ-012 SHALL have port uart_tx  output  1  serial line; idle high.

Function
REQ-013 SHALL accept an access in any cycle with mem_valid & mem_sel & !mem_ready, and assert mem_ready for exactly one cycle on the next edge.
REQ-014 SHALL perform a write's register effect on the accept edge, and register read data on that same edge.
REQ-015 SHALL decode mem_addr[11:2] as follows: 0x000 DATA (WO), 0x004 STATUS (RW1C), 0x008 BAUD_DIV (RW); other offsets SHALL read 0, ignore writes and still complete.
REQ-016 DATA write SHALL push mem_wdata[7:0] into the FIFO if the FIFO is not full at the start of the cycle; otherwise the byte SHALL be dropped and overflow set to 1. DATA SHALL read 0.
REQ-017 STATUS read SHALL return: [0] full, [1] empty, [2] busy (FSM not IDLE), [3] overflow, [15:8] FIFO level, all other bits 0.
REQ-018 STATUS write with mem_wdata[3]=1 SHALL clear overflow; if an overflow event occurs in the same cycle, set SHALL win.
REQ-019 BAUD_DIV SHALL be 16 bits (mem_wdata[15:0]); reads SHALL zero-extend.
REQ-020 A new BAUD_DIV value SHALL take effect at the next bit boundary.
REQ-021 A push and a pop in the same cycle SHALL leave the level unchanged; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-023 IDLE: uart_tx=1; if the FIFO is non-empty, the FSM SHALL pop one byte and move to START on that edge.
REQ-024 START SHALL drive 0 for one bit period, then move to DATA.
REQ-025 DATA SHALL shift out 8 bits LSB first, one bit period each, using a 3-bit bit counter, then move to STOP.
REQ-026 STOP SHALL drive 1 for one bit period, then return to IDLE; back-to-back frames therefore have no extra idle cycles beyond the single IDLE pop cycle.
REQ-027 The bit timer SHALL load BAUD_DIV at each bit start, decrement each clock, and declare a bit boundary on reaching 0.
REQ-028 uart_tx SHALL be driven from a register.
REQ-029 With an idle FSM and an empty FIFO, uart_tx SHALL fall on the second edge after the DATA write accept edge.

Reset
REQ-030 While reset_=0 at an edge, the block SHALL set: mem_ready=0, mem_rdata=0, uart_tx=1, FSM=IDLE, FIFO empty (pointers 0), overflow=0, BAUD_DIV=BAUD_DIV_RESET, bit timer 0.
REQ-031 A reset mid-frame SHALL abort the frame: uart_tx SHALL be 1 after the reset edge, queued bytes SHALL be discarded, and no partial frame SHALL resume.
REQ-032 An access pending during reset SHALL NOT complete; mem_valid SHALL be ignored while reset_=0.

Verification
REQ-033 SHALL check: after reset, read 0x008 -> 0x000001B1 and read 0x004 -> 0x00000002 with mem_ready high for exactly 1 cycle each.
REQ-034 SHALL check: write BAUD_DIV=3, then DATA=0x55 -> uart_tx low 2 edges after accept; the bit sequence is 0,1,0,1,0,1,0,1,0,1 with each bit 4 clocks, followed by idle high.
REQ-035 SHALL check: BAUD_DIV=3, then write DATA 0xA1..0xA6 back-to-back -> 0xA6 dropped, STATUS=0x0000040D; frames A1..A5 are sent in order.
REQ-036 SHALL check: after the overflow scenario, write STATUS=0x8 -> bit 3 clears; read offset 0x010 -> 0 and completes in 1 cycle.
REQ-037 SHALL check: assert reset_=0 during DATA bit 3 of a frame -> uart_tx=1 after the next edge, STATUS=0x00000002, and no further frames are sent.
REQ-038 SHALL check: change BAUD_DIV from 3 to 7 mid-frame -> the current bit keeps 4 clocks and subsequent bits are 8 clocks.
